instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WORD_WIDTH, 32, data and address width.
- DEPTH_WORDS, 1024, number of word locations (power of two).
- LATENCY, 1, cycles from grant edge to rvalid (legal range 1..4).
- GNT_STALL, 0, cycles a request waits before grant (legal range 0..7).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, reset, synchronous and active-low.
- instr_req_i, in, 1, fetch request; held high by the initiator until granted.
- instr_addr_i, in, WORD_WIDTH, byte address of the request.
- instr_gnt_o, out, 1, request accepted this cycle; the address may change next cycle.
- instr_rvalid_o, out, 1, instr_rdata_o is valid this cycle.
- instr_rdata_o, out, WORD_WIDTH, returned instruction word.
- instr_err_o, out, 1, response is for a misaligned or out-of-range address; valid only with rvalid.
- prog_we_i, in, 1, program-load write enable.
- prog_addr_i, in, WORD_WIDTH, program-load byte address (word aligned).
- prog_wdata_i, in, WORD_WIDTH, program-load data.

Function
REQ-003 Storage SHALL be DEPTH_WORDS words; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-004 The grant FSM SHALL have two states, IDLE and WAIT; stall_cnt SHALL be 3 bits.
REQ-005 IDLE with instr_req_i=1 and GNT_STALL=0: instr_gnt_o=1 combinationally in the same cycle; state stays IDLE.
REQ-006 IDLE with instr_req_i=1 and GNT_STALL>0: go to WAIT and set stall_cnt=1; instr_gnt_o=0.
REQ-007 WAIT: instr_gnt_o=1 when stall_cnt==GNT_STALL and instr_req_i=1, then return to IDLE with stall_cnt=0; otherwise stall_cnt increments by one.
REQ-008 WAIT with instr_req_i=0 (protocol violation): return to IDLE with stall_cnt=0 and no grant.
REQ-009 instr_gnt_o SHALL never be 1 while instr_req_i=0.
REQ-010 On a grant edge, the module SHALL read the array at the captured address and push {data, err} into a LATENCY-deep valid/data shift pipeline.
REQ-011 The response SHALL appear on instr_rvalid_o, instr_rdata_o and instr_err_o exactly LATENCY rising edges after the grant edge, for exactly one cycle.
REQ-012 Back-to-back grants (one per cycle) SHALL produce back-to-back rvalid cycles, in order, with no loss; up to LATENCY responses may be outstanding.
REQ-013 When addr[1:0]!=0 or the address is at or beyond DEPTH_WORDS*4, instr_rdata_o SHALL be 32'h0000_0013 (NOP) and instr_err_o=1; otherwise instr_err_o=0.
REQ-014 When instr_rvalid_o=0, instr_rdata_o SHALL hold 0 and instr_err_o SHALL be 0.
REQ-015 prog_we_i SHALL write prog_wdata_i at the rising edge; out-of-range or misaligned writes SHALL be ignored.
REQ-016 A write and a grant to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-017 The responder SHALL never stall or back-pressure responses; rvalid carries no ready handshake.

Reset
REQ-018 While rst_n=0 at a clock edge: state=IDLE, stall_cnt=0, the whole pipeline invalid, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0.
REQ-019 instr_gnt_o SHALL be 0 during any cycle with rst_n=0.
REQ-020 Reset asserted mid-operation SHALL discard all outstanding responses; none may appear after reset deasserts.
REQ-021 Array contents SHALL NOT be cleared by reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Load: load 0x00500093 at 0x0; LATENCY=1, GNT_STALL=0; req addr 0x0 -> gnt in the same cycle; rvalid one edge later with rdata=0x00500093 and err=0.
- Stall and latency: GNT_STALL=3, LATENCY=2; req held -> gnt on the 4th req cycle; rvalid 2 edges after the grant.
- Streaming: LATENCY=3; 8 consecutive granted requests at 0x0..0x1C -> 8 consecutive rvalid cycles with data in order.
- Bad addresses: req 0x2 -> rdata=0x00000013 and err=1; req at DEPTH_WORDS*4 -> same response.
- Reset: reset asserted with 2 responses outstanding -> no rvalid afterwards; all outputs 0 during reset.
- Collision: write 0xDEADBEEF to 0x10 in the same cycle as a grant to 0x10 -> old data returned; the next read returns 0xDEADBEEF.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder.
// Accepts req/gnt fetches with a configurable grant stall, returns {rdata, err}
// a fixed LATENCY edges after each grant, and exposes a write port for program load.
module instr_mem_responder #(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int GNT_STALL   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  prog_we_i,
  input  logic [WORD_WIDTH-1:0] prog_addr_i,
  input  logic [WORD_WIDTH-1:0] prog_wdata_i
);

  localparam int                    AW        = $clog2(DEPTH_WORDS);
  localparam logic [WORD_WIDTH:0]   MEM_BYTES = (WORD_WIDTH+1)'(DEPTH_WORDS) << 2;
  localparam logic [WORD_WIDTH-1:0] NOP       = WORD_WIDTH'(32'h0000_0013);
  localparam logic [2:0]            STALL     = 3'(GNT_STALL);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  err;
  } resp_t;

  state_t                state_q, state_d;
  logic [2:0]            stall_cnt_q, stall_cnt_d;
  logic                  gnt;
  logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];
  resp_t                 rd_resp;
  logic [LATENCY:1]      vld_pipe;
  resp_t                 resp_pipe [LATENCY:1];

  // Misaligned or past the end of the array.
  function automatic logic bad_addr(input logic [WORD_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= MEM_BYTES);
  endfunction

  // Grant FSM next state: count stall cycles while the request is held.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    gnt         = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_req_i) begin
          if (GNT_STALL == 0) begin
            gnt = 1'b1;
          end else begin
            state_d     = WAIT;
            stall_cnt_d = 3'd1;
          end
        end
      end
      WAIT: begin
        if (!instr_req_i) begin
          // initiator dropped the request: abandon it, no grant
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else if (stall_cnt_q == STALL) begin
          gnt         = 1'b1;
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        stall_cnt_d = '0;
      end
    endcase
    if (!rst_n) gnt = 1'b0;
  end

  // Grant FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Read side is asynchronous so a same-edge write is not yet visible (read-before-write).
  always_comb begin
    rd_resp.err  = bad_addr(instr_addr_i);
    rd_resp.data = rd_resp.err ? NOP : mem[instr_addr_i[AW+1:2]];
  end

  // Program-load write port; array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_we_i && !bad_addr(prog_addr_i))
      mem[prog_addr_i[AW+1:2]] <= prog_wdata_i;
  end

  // Valid shift register; reset drops every outstanding response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= gnt;
      for (int k = 2; k <= LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Payload shift register; qualified by vld_pipe so it needs no reset.
  always_ff @(posedge clk) begin
    resp_pipe[1] <= rd_resp;
    for (int k = 2; k <= LATENCY; k++) resp_pipe[k] <= resp_pipe[k-1];
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rst_n & vld_pipe[LATENCY];
  assign instr_rdata_o  = instr_rvalid_o ? resp_pipe[LATENCY].data : '0;
  assign instr_err_o    = instr_rvalid_o & resp_pipe[LATENCY].err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances with different LATENCY/GNT_STALL
// driven by list-based initiators, checked every cycle against a response schedule model.
module tb_instr_mem_responder;

  localparam int DEPTH = 64;
  localparam int ND    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [ND];
  logic [31:0] addr   [ND];
  logic        gnt    [ND];
  logic        rvalid [ND];
  logic [31:0] rdata  [ND];
  logic        err    [ND];
  logic        prog_we;
  logic [31:0] prog_addr, prog_wdata;

  always #5 clk = ~clk;

  instr_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .GNT_STALL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata));

  instr_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2), .GNT_STALL(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata));

  instr_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(3), .GNT_STALL(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata));

  int          checks, errors, cyc, gap_pct;
  bit          rnd_prog;
  logic [31:0] ref_mem [DEPTH];
  int          held  [ND];
  bit          busy  [ND];
  logic [31:0] alist [ND][64];
  int          alen  [ND];
  int          aptr  [ND];
  // expected response per instance, indexed by (cycle it must appear) mod 8
  bit          ev [ND][8];
  logic [31:0] ed [ND][8];
  bit          ee [ND][8];

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int stall_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(99);
    if (r < 80)      return 32'($urandom_range(DEPTH - 1) * 4);
    else if (r < 90) return 32'($urandom_range(DEPTH - 1) * 4 + $urandom_range(3, 1));
    else             return 32'(DEPTH * 4 + $urandom_range(4095));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic [31:0] a);
    alist[d][alen[d]] = a;
    alen[d]++;
  endtask

  task automatic clear_lists();
    for (int d = 0; d < ND; d++) begin
      alen[d] = 0;
      aptr[d] = 0;
    end
  endtask

  // One clock cycle: drive inputs after negedge, check, advance the model, wait next negedge.
  task automatic step();
    int s, sn;
    bit eg, be;
    if (rnd_prog) begin
      prog_we    = ($urandom_range(99) < 20);
      prog_addr  = rand_addr();
      prog_wdata = $urandom;
    end
    for (int d = 0; d < ND; d++) begin
      if (!busy[d]) begin
        if (aptr[d] < alen[d] && $urandom_range(99) >= gap_pct) begin
          busy[d] = 1'b1;
          req[d]  = 1'b1;
          addr[d] = alist[d][aptr[d]];
        end else begin
          req[d]  = 1'b0;
          addr[d] = $urandom;
        end
      end
    end
    #1;
    s = cyc % 8;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) ev[d][k] = 1'b0;
      end
      chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(ev[d][s]));
      chk($sformatf("rdata%0d", d), rdata[d], ev[d][s] ? ed[d][s] : 32'h0);
      chk($sformatf("err%0d", d), 32'(err[d]), ev[d][s] ? 32'(ee[d][s]) : 32'h0);
      ev[d][s] = 1'b0;
      // grant comes after the request has been held GNT_STALL full cycles
      eg = rst_n && req[d] && (held[d] == stall_of(d));
      chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(eg));
      if (eg) begin
        sn = (cyc + lat_of(d)) % 8;
        be = bad(addr[d]);
        ev[d][sn] = 1'b1;
        ee[d][sn] = be;
        ed[d][sn] = be ? 32'h0000_0013 : ref_mem[addr[d] / 4];
      end
      if (!rst_n || !req[d] || eg) held[d] = 0;
      else                         held[d]++;
      if (busy[d] && rst_n && gnt[d] === 1'b1) begin
        busy[d] = 1'b0;
        aptr[d]++;
      end
    end
    if (prog_we && !bad(prog_addr)) ref_mem[prog_addr / 4] = prog_wdata;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_lists(input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = 1'b1;
      for (int d = 0; d < ND; d++)
        if (busy[d] || aptr[d] < alen[d]) done = 1'b0;
    end
    chk("timeout", 32'(done), 32'h1);
    repeat (6) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gap_pct = 0; rnd_prog = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req[d] = 1'b0; addr[d] = '0; busy[d] = 1'b0; held[d] = 0;
      for (int k = 0; k < 8; k++) ev[d][k] = 1'b0;
    end
    clear_lists();
    @(negedge clk);

    // reset: all outputs quiet
    repeat (3) step();
    rst_n = 1'b1;

    // program load, then writes that must be dropped (misaligned / out of range)
    for (int i = 0; i < DEPTH; i++) begin
      prog_we    = 1'b1;
      prog_addr  = 32'(i * 4);
      prog_wdata = (i == 0) ? 32'h0050_0093 : $urandom;
      step();
    end
    prog_addr = 32'h6;              prog_wdata = 32'h1111_1111; step();
    prog_addr = 32'(DEPTH * 4);     prog_wdata = 32'h2222_2222; step();
    prog_addr = 32'(DEPTH * 4 + 16); prog_wdata = 32'h3333_3333; step();
    prog_addr = 32'h13;             prog_wdata = 32'h4444_4444; step();
    prog_we = 1'b0;

    // first fetch of word 0 on every instance (stall/latency exercised on u_dut1)
    clear_lists();
    for (int d = 0; d < ND; d++) push(d, 32'h0);
    run_lists(50);

    // streaming 0x00..0x1C back to back
    clear_lists();
    for (int i = 0; i < 8; i++) begin
      push(0, 32'(i * 4));
      push(1, 32'(i * 4));
      push(2, 32'(i * 4));
    end
    run_lists(100);

    // bad addresses: misaligned and first out-of-range byte
    clear_lists();
    for (int d = 0; d < ND; d++) begin
      push(d, 32'h2);
      push(d, 32'(DEPTH * 4));
      push(d, 32'(DEPTH * 4 - 4));
    end
    run_lists(50);

    // collision: write and grant to 0x10 in the same cycle, then re-read
    clear_lists();
    push(0, 32'h10);
    push(0, 32'h10);
    prog_we = 1'b1; prog_addr = 32'h10; prog_wdata = 32'hDEAD_BEEF;
    step();
    prog_we = 1'b0;
    run_lists(20);

    // reset with two responses outstanding on the LATENCY=3 instance
    clear_lists();
    push(2, 32'h0);
    push(2, 32'h4);
    push(2, 32'h8);
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    run_lists(20);

    // randomized traffic with gaps and concurrent program writes
    clear_lists();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 40; i++) push(d, rand_addr());
    gap_pct  = 30;
    rnd_prog = 1'b1;
    run_lists(2000);
    rnd_prog = 1'b0;
    prog_we  = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
